par_scrambler: RTL and testbench

PAR_SCRAMBLER -- requirements
Module: par_scrambler

---
 rtl/par_scrambler_pkg.sv | 11 +
 rtl/par_scrambler_lfsr_step.sv | 33 +++
 rtl/par_scrambler.sv | 107 ++++++++++
 tb/tb_par_scrambler.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/par_scrambler_pkg.sv
// rtl/par_scrambler_pkg.sv - mode encodings and default polynomial/seed for par_scrambler
package par_scrambler_pkg;

    localparam logic MODE_ADD   = 1'b0;
    localparam logic MODE_SSYNC = 1'b1;

    localparam int          DEF_LFSR_W = 15;
    localparam logic [14:0] DEF_TAPS   = 15'h6000;
    localparam logic [14:0] DEF_SEED   = 15'h7FFF;

endpackage

// File: rtl/par_scrambler_lfsr_step.sv
// rtl/par_scrambler_lfsr_step.sv - one combinational scrambler bit step (module lfsr_step)
module lfsr_step
    import par_scrambler_pkg::*;
#(
    parameter int                LFSR_W = DEF_LFSR_W,
    parameter logic [LFSR_W-1:0] TAPS   = DEF_TAPS
) (
    input  logic [LFSR_W-1:0] i_state,
    input  logic              i_bit,
    input  logic              i_mode,
    input  logic              i_descramble,
    output logic [LFSR_W-1:0] o_state,
    output logic              o_bit
);

    logic w_fb;
    logic w_d;

    // Feedback, output bit and the bit shifted into the register for this step
    always_comb begin
        w_fb  = ^(i_state & TAPS);
        o_bit = i_bit ^ w_fb;
        if (i_mode == MODE_ADD) begin
            w_d = w_fb;
        end else if (i_descramble) begin
            w_d = i_bit;
        end else begin
            w_d = o_bit;
        end
        o_state = {i_state[LFSR_W-2:0], w_d};
    end

endmodule

// File: rtl/par_scrambler.sv
// rtl/par_scrambler.sv - parallel additive/self-sync scrambler; optional SCRAMBLER_ZERO_GUARD_EN lockup guard
module par_scrambler
    import par_scrambler_pkg::*;
#(
    parameter int                LFSR_W = DEF_LFSR_W,
    parameter logic [LFSR_W-1:0] TAPS   = DEF_TAPS,
    parameter logic [LFSR_W-1:0] SEED   = DEF_SEED,
    parameter int                DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              mode,
    input  logic              descramble,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed_in,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [LFSR_W-1:0] state_out
`ifdef SCRAMBLER_ZERO_GUARD_EN
    ,
    output logic              lockup
`endif
);

    logic [LFSR_W-1:0] r_state;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;

    logic [LFSR_W-1:0] w_chain [0:DATA_W];
    logic [DATA_W-1:0] w_data;
    logic [LFSR_W-1:0] w_next;
    logic              w_accept;
    logic              w_out_xfer;

    assign in_ready   = enable & ~seed_load & (~r_out_valid | out_ready);
    assign w_accept   = in_valid & in_ready;
    assign w_out_xfer = r_out_valid & out_ready;
    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign state_out  = r_state;
    assign w_chain[0] = r_state;

    // Bit steps chained LSB first so a whole beat completes in one cycle
    for (genvar g = 0; g < DATA_W; g++) begin : g_step
        lfsr_step #(
            .LFSR_W (LFSR_W),
            .TAPS   (TAPS)
        ) u_step (
            .i_state      (w_chain[g]),
            .i_bit        (in_data[g]),
            .i_mode       (mode),
            .i_descramble (descramble),
            .o_state      (w_chain[g+1]),
            .o_bit        (w_data[g])
        );
    end

`ifdef SCRAMBLER_ZERO_GUARD_EN
    logic r_lockup;
    logic w_zero;

    assign w_zero = (w_chain[DATA_W] == '0) && (mode == MODE_ADD);
    assign w_next = w_zero ? SEED : w_chain[DATA_W];
    assign lockup = r_lockup;

    // One-cycle lockup pulse when an additive beat would have zeroed the register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lockup <= 1'b0;
        end else begin
            r_lockup <= enable & w_accept & w_zero;
        end
    end
`else
    assign w_next = w_chain[DATA_W];
`endif

    // LFSR state: seed load has priority, otherwise advance only on an accepted beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= SEED;
        end else if (enable && seed_load) begin
            r_state <= seed_in;
        end else if (w_accept) begin
            r_state <= w_next;
        end
    end

    // Output register: load on accept, clear when drained with nothing new behind it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_data;
        end else if (w_out_xfer) begin
            r_out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_par_scrambler.sv
// tb/tb_par_scrambler.sv - self-checking bench for par_scrambler
module tb_par_scrambler;

    localparam int MASK = 32'h7FFF;
    localparam int TAPS = 32'h6000;
    localparam int SEED = 32'h7FFF;
`ifdef SCRAMBLER_ZERO_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        mode;
    logic        descramble;
    logic        seed_load;
    logic [14:0] seed_in;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready;
    logic [14:0] state_out;

    logic        d_in_valid;
    logic        d_in_ready;
    logic        d_out_valid;
    logic [7:0]  d_out_data;
    logic [14:0] d_state_out;
`ifdef SCRAMBLER_ZERO_GUARD_EN
    logic        lockup;
    logic        d_lockup;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    par_scrambler u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .mode       (mode),
        .descramble (descramble),
        .seed_load  (seed_load),
        .seed_in    (seed_in),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .state_out  (state_out)
`ifdef SCRAMBLER_ZERO_GUARD_EN
        ,
        .lockup     (lockup)
`endif
    );

    assign d_in_valid = out_valid & out_ready;

    par_scrambler #(.SEED(15'h1234)) u_desc (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (1'b1),
        .mode       (1'b1),
        .descramble (1'b1),
        .seed_load  (1'b0),
        .seed_in    (15'h0000),
        .in_valid   (d_in_valid),
        .in_data    (out_data),
        .in_ready   (d_in_ready),
        .out_valid  (d_out_valid),
        .out_data   (d_out_data),
        .out_ready  (1'b1),
        .state_out  (d_state_out)
`ifdef SCRAMBLER_ZERO_GUARD_EN
        ,
        .lockup     (d_lockup)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference beat: walk the bits LSB first using integer arithmetic
    function automatic void ref_beat(input int st, input int din, input bit m, input bit dsc,
                                     output int nst, output int dout);
        int b, fb, ob, d;
        dout = 0;
        for (int i = 0; i < 8; i++) begin
            b  = (din >> i) & 1;
            fb = $countones(st & TAPS) % 2;
            ob = b ^ fb;
            if (!m)       d = fb;
            else if (dsc) d = b;
            else          d = ob;
            st   = ((st << 1) | d) & MASK;
            dout = dout | (ob << i);
        end
        nst = st;
    endfunction

    task automatic idle_inputs();
        enable = 1'b1; mode = 1'b0; descramble = 1'b0; seed_load = 1'b0;
        seed_in = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic        m;
        logic        dsc;
        logic [7:0]  din;
        logic [7:0]  dout;
        logic [14:0] st;
    } vec_t;

    vec_t vecs [6];

    int   m_state, m_od, nst, nod, t_st, t_od;
    bit   m_ov, m_lock, nov, nlock, exp_ready, acc;
    byte  sent [$];
    byte  rcvd [$];

    initial begin
        vecs[0] = '{1'b0, 1'b0, 8'h00, 8'h00, 15'h7F00};
        vecs[1] = '{1'b0, 1'b0, 8'h00, 8'h40, 15'h0002};
        vecs[2] = '{1'b0, 1'b0, 8'h00, 8'h00, 15'h0200};
        vecs[3] = '{1'b0, 1'b0, 8'hFF, 8'hCF, 15'h000C};
        vecs[4] = '{1'b1, 1'b0, 8'h00, 8'h00, 15'h0C00};
        vecs[5] = '{1'b1, 1'b1, 8'hFF, 8'hEB, 15'h00FF};

        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_out_valid", out_valid, 0);
        check("reset_out_data", out_data, 0);
        check("reset_state", state_out, SEED);
`ifdef SCRAMBLER_ZERO_GUARD_EN
        check("reset_lockup", lockup, 0);
`endif
        rst_n = 1'b1;

        // Hand-computed vectors from SEED, back to back
        for (int i = 0; i < 6; i++) begin
            mode = vecs[i].m; descramble = vecs[i].dsc;
            in_valid = 1'b1; in_data = vecs[i].din;
            #1 check("vec_in_ready", in_ready, 1);
            @(negedge clk);
            check($sformatf("vec%0d_valid", i), out_valid, 1);
            check($sformatf("vec%0d_data", i), out_data, vecs[i].dout);
            check($sformatf("vec%0d_state", i), state_out, vecs[i].st);
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("vec_drain_valid", out_valid, 0);

        // Backpressure: one accept then five stalled cycles
        do_reset();
        in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check("bp_in_ready", in_ready, 0);
            check("bp_out_valid", out_valid, 1);
            check("bp_out_data", out_data, 8'hA5);
            check("bp_state", state_out, 15'h7F00);
            @(negedge clk);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid", out_valid, 0);

        // Seed load mid-stream blocks the input and restarts from the loaded value
        in_valid = 1'b1; in_data = 8'h00;
        @(negedge clk);
        check("sl_pre_data", out_data, 8'h40);
        seed_load = 1'b1; seed_in = 15'h7FFF;
        #1 check("sl_in_ready", in_ready, 0);
        @(negedge clk);
        check("sl_state", state_out, 15'h7FFF);
        check("sl_valid_drained", out_valid, 0);
        seed_load = 1'b0; in_data = 8'h00;
        @(negedge clk);
        check("sl_post_data", out_data, 8'h00);
        check("sl_post_state", state_out, 15'h7F00);

        // Reset in the middle of a stalled beat
        in_valid = 1'b1; in_data = 8'h00; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        check("rst_pre_valid", out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_valid", out_valid, 0);
        check("rst_async_state", state_out, SEED);
        check("rst_async_data", out_data, 0);
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        in_valid = 1'b1; in_data = 8'h00;
        @(negedge clk);
        in_valid = 1'b0;
        check("rst_first_data", out_data, 8'h00);
        check("rst_first_state", state_out, 15'h7F00);

`ifdef SCRAMBLER_ZERO_GUARD_EN
        // Zero seed in additive mode triggers the guard reload
        @(negedge clk);
        seed_load = 1'b1; seed_in = 15'h0000;
        @(negedge clk);
        seed_load = 1'b0; mode = 1'b0; in_valid = 1'b1; in_data = 8'h3C;
        @(negedge clk);
        in_valid = 1'b0;
        check("guard_lockup", lockup, 1);
        check("guard_state", state_out, SEED);
        @(negedge clk);
        check("guard_lockup_clear", lockup, 0);
`endif

        // Randomised traffic against the reference model
        do_reset();
        m_state = SEED; m_ov = 0; m_od = 0; m_lock = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            check("rnd_out_valid", out_valid, m_ov);
            check("rnd_out_data", out_data, m_od);
            check("rnd_state", state_out, m_state);
`ifdef SCRAMBLER_ZERO_GUARD_EN
            check("rnd_lockup", lockup, m_lock);
`endif
            enable     = ($urandom_range(0, 9) != 0);
            seed_load  = ($urandom_range(0, 19) == 0);
            seed_in    = ($urandom_range(0, 7) == 0) ? 15'h0 : 15'($urandom_range(0, 32767));
            mode       = 1'($urandom);
            descramble = 1'($urandom);
            in_valid   = ($urandom_range(0, 9) < 7);
            in_data    = 8'($urandom);
            out_ready  = ($urandom_range(0, 9) < 7);
            exp_ready  = enable && !seed_load && (!m_ov || out_ready);
            #1 check("rnd_in_ready", in_ready, exp_ready);
            acc = in_valid && exp_ready;
            nst = m_state; nov = m_ov; nod = m_od; nlock = 0;
            if (enable && seed_load) begin
                nst = seed_in;
            end else if (acc) begin
                ref_beat(m_state, in_data, mode, descramble, t_st, t_od);
                if (GUARD && !mode && t_st == 0) begin
                    t_st  = SEED;
                    nlock = 1;
                end
                nst = t_st; nov = 1; nod = t_od;
            end
            if (!acc && m_ov && out_ready) nov = 0;
            @(negedge clk);
            m_state = nst; m_ov = nov; m_od = nod; m_lock = nlock;
        end

        // Round trip through the self-sync descrambler with a different seed
        do_reset();
        mode = 1'b1; descramble = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 24; i++) begin
            if (d_out_valid) rcvd.push_back(d_out_data);
            in_valid = 1'b1; in_data = 8'($urandom);
            #1;
            if (in_ready) sent.push_back(in_data);
            @(negedge clk);
        end
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (d_out_valid) rcvd.push_back(d_out_data);
            @(negedge clk);
        end
        check("rt_count", rcvd.size(), sent.size());
        for (int i = 2; i < sent.size() && i < rcvd.size(); i++) begin
            check($sformatf("rt_beat%0d", i), rcvd[i], sent[i]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
